// File: rtl/alu_multicycle_ctrl_pkg.sv
// Shared ALU encodings and sizing for the multi-cycle MUL/DIV/POW sequencer.
package alu_multicycle_ctrl_pkg;

   localparam int ALU_W       = 32;
   localparam int POW_MAX_EXP = 8;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      AND = 3'b010,
      ORR = 3'b011,
      MUL = 3'b100,
      DIV = 3'b101,
      POW = 3'b110
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mc_state_t;

endpackage

// File: rtl/alu_multicycle_ctrl_iter_mul.sv
// Radix-2 shift-add multiplier keeping the low W bits; one multiplier bit per step.
module alu_multicycle_ctrl_iter_mul #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         load_i,
   input  logic         step_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] product_o,
   output logic         last_o
);
   import alu_multicycle_ctrl_pkg::*;

   localparam int CW = $clog2(W);

   logic [W-1:0]  mcand_q, mcand_d;
   logic [W-1:0]  mplier_q, mplier_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  acc_step;

   // product_o already includes the current step, so the last step's value is usable on its own edge
   assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign product_o = acc_step;
   assign last_o    = (cnt_q == CW'(W - 1));

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (load_i) begin
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step_i) begin
         mcand_d  = {mcand_q[W-2:0], 1'b0};
         mplier_d = {1'b0, mplier_q[W-1:1]};
         acc_d    = acc_step;
         cnt_d    = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_multicycle_ctrl.sv
// Iterative sequencer for MUL / unsigned DIV / POW with start-busy-done handshake and abort.
module alu_multicycle_ctrl #(
   parameter int WIDTH       = alu_multicycle_ctrl_pkg::ALU_W,
   parameter int POW_MAX_EXP = alu_multicycle_ctrl_pkg::POW_MAX_EXP
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [3:0]       flags_o
);
   import alu_multicycle_ctrl_pkg::*;

   localparam logic [1:0] S_IDLE    = IDLE;
   localparam logic [1:0] S_RUN     = RUN;
   localparam logic [1:0] S_DONE    = DONE;
   localparam logic [3:0] EXP_MAX   = 4'(POW_MAX_EXP);
   localparam logic [4:0] ITER_LAST = 5'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] base_q, base_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [4:0]       iter_q, iter_d;
   logic [3:0]       pass_q, pass_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic             mul_load, mul_step, mul_last;
   logic [WIDTH-1:0] mul_a, mul_b, mul_product;

   logic [WIDTH:0]   rem_shift, rem_diff;
   logic             q_bit;
   logic             fin;
   logic [WIDTH-1:0] fin_val;
   logic [3:0]       pow_e;

   assign pow_e = b_i[3:0];

   alu_multicycle_ctrl_iter_mul #(
      .W (WIDTH)
   ) u_mul (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .load_i    (mul_load),
      .step_i    (mul_step),
      .a_i       (mul_a),
      .b_i       (mul_b),
      .product_o (mul_product),
      .last_o    (mul_last)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      base_d   = base_q;
      dvsr_d   = dvsr_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      iter_d   = iter_q;
      pass_d   = pass_q;
      result_d = result_q;
      flags_d  = flags_q;
      mul_load = 1'b0;
      mul_step = 1'b0;
      mul_a    = base_q;
      mul_b    = base_q;
      fin      = 1'b0;
      fin_val  = '0;

      // restoring division: shift in the next dividend bit, subtract if it fits
      rem_shift = {rem_q, quot_q[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, dvsr_q};
      q_bit     = ~rem_diff[WIDTH];

      case (state_q)
         S_IDLE: begin
            if (start_i && !abort_i) begin
               op_d   = op_i;
               base_d = a_i;
               dvsr_d = b_i;
               quot_d = a_i;
               rem_d  = '0;
               iter_d = '0;
               pass_d = 4'd1;
               case (op_i)
                  MUL: begin
                     mul_load = 1'b1;
                     mul_a    = a_i;
                     mul_b    = b_i;
                     state_d  = S_RUN;
                  end
                  DIV: begin
                     if (b_i == '0) fin = 1'b1;
                     else           state_d = S_RUN;
                  end
                  POW: begin
                     if (pow_e == 4'd0) begin
                        fin     = 1'b1;
                        fin_val = WIDTH'(1);
                     end else if (pow_e == 4'd1) begin
                        fin     = 1'b1;
                        fin_val = a_i;
                     end else if (pow_e > EXP_MAX) begin
                        fin     = 1'b1;
                        fin_val = '1;
                     end else begin
                        mul_load = 1'b1;
                        mul_a    = a_i;
                        mul_b    = a_i;
                        pass_d   = pow_e - 4'd1;
                        state_d  = S_RUN;
                     end
                  end
                  default: fin = 1'b1;
               endcase
            end
         end
         S_RUN: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else begin
               iter_d = iter_q + 5'd1;
               if (op_q == DIV) begin
                  quot_d = {quot_q[WIDTH-2:0], q_bit};
                  rem_d  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                  if (iter_q == ITER_LAST) begin
                     fin     = 1'b1;
                     fin_val = {quot_q[WIDTH-2:0], q_bit};
                  end
               end else begin
                  mul_step = 1'b1;
                  if (mul_last) begin
                     if (pass_q == 4'd1) begin
                        fin     = 1'b1;
                        fin_val = mul_product;
                     end else begin
                        // POW: chain the next acc*a pass without a gap cycle
                        pass_d   = pass_q - 4'd1;
                        mul_load = 1'b1;
                        mul_a    = mul_product;
                        mul_b    = base_q;
                     end
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (fin) begin
         state_d  = S_DONE;
         result_d = fin_val;
         flags_d  = {fin_val[WIDTH-1], (fin_val == '0), 2'b00};
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         base_q   <= '0;
         dvsr_q   <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         iter_q   <= '0;
         pass_q   <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         base_q   <= base_d;
         dvsr_q   <= dvsr_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         iter_q   <= iter_d;
         pass_q   <= pass_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign busy_o   = (state_q != S_IDLE);
   assign done_o   = (state_q == S_DONE);
   assign result_o = result_q;
   assign flags_o  = flags_q;

endmodule

// File: tb/tb_alu_multicycle_ctrl.sv
// Self-checking bench for alu_multicycle_ctrl: directed spec cases plus random ops against an arithmetic model.
module tb_alu_multicycle_ctrl;

   logic        clk_i   = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  op_i    = 3'd0;
   logic [31:0] a_i     = 32'd0;
   logic [31:0] b_i     = 32'd0;
   logic        abort_i = 1'b0;
   logic        busy_o, done_o;
   logic [31:0] result_o;
   logic [3:0]  flags_o;

   int          n_cmp    = 0;
   int          n_fail   = 0;
   logic [31:0] last_res = 32'd0;
   logic [3:0]  last_flg = 4'd0;

   always #5 clk_i = ~clk_i;

   alu_multicycle_ctrl dut (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .start_i  (start_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .abort_i  (abort_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o),
      .flags_o  (flags_o)
   );

   function automatic logic [3:0] ref_flags(input logic [31:0] r);
      return {r[31], (r == 32'd0), 2'b00};
   endfunction

   // Reference: result by plain arithmetic, latency in cycles after the accepting cycle
   function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
      int e;
      r   = 32'd0;
      lat = 1;
      case (op)
         3'b100: begin r = a * b; lat = 33; end
         3'b101: if (b != 32'd0) begin r = a / b; lat = 33; end
         3'b110: begin
            e = int'(b[3:0]);
            if (e == 0)      r = 32'd1;
            else if (e == 1) r = a;
            else if (e > 8)  r = 32'hFFFF_FFFF;
            else begin
               r = a;
               for (int k = 1; k < e; k++) r = r * a;
               lat = 32 * (e - 1) + 1;
            end
         end
         default: ;
      endcase
   endfunction

   // Issue one op from IDLE (called #1 after an edge); returns what was observed at done
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic [3:0] flg,
                        output bit busy_ok, output bit tail_ok);
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(posedge clk_i); #1;
      start_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
      lat = -1; res = 32'd0; flg = 4'd0; busy_ok = 1'b1; tail_ok = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         if (busy_o !== 1'b1) busy_ok = 1'b0;
         if (done_o === 1'b1) begin
            lat = c; res = result_o; flg = flags_o;
            break;
         end
         @(posedge clk_i); #1;
      end
      if (lat > 0) begin
         @(posedge clk_i); #1;
         tail_ok = (done_o === 1'b0) && (busy_o === 1'b0) && (result_o === res) && (flags_o === flg);
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      n_cmp++;
      if ({busy_o, done_o, result_o, flags_o} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b result=%h flags=%b, want all 0",
                  busy_o, done_o, result_o, flags_o);
      end
      reset_i = 1'b0;
      @(posedge clk_i); #1;
      n_cmp++;
      if ({busy_o, done_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy_o, done_o);
      end
   endtask

   task automatic test_mul_div();
      logic [2:0]  ops [6] = '{3'b100, 3'b100, 3'b101, 3'b101, 3'b000, 3'b111};
      logic [31:0] as  [6] = '{32'd7, 32'hFFFF_FFFF, 32'd100, 32'd5, 32'd3, 32'd9};
      logic [31:0] bs  [6] = '{32'd6, 32'd2, 32'd7, 32'd0, 32'd4, 32'd9};
      logic [31:0] ers [6] = '{32'd42, 32'hFFFF_FFFE, 32'd14, 32'd0, 32'd0, 32'd0};
      logic [3:0]  efs [6] = '{4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
      int          els [6] = '{33, 33, 33, 1, 1, 1};
      int lat; logic [31:0] res; logic [3:0] flg; bit bok, tok;
      for (int i = 0; i < 6; i++) begin
         do_op(ops[i], as[i], bs[i], lat, res, flg, bok, tok);
         $display("muldiv op=%b a=%h b=%h result=%h flags=%b cycles=%0d", ops[i], as[i], bs[i], res, flg, lat);
         n_cmp++;
         if (lat !== els[i]) begin n_fail++; $display("FAIL muldiv_latency[%0d]: got %0d want %0d", i, lat, els[i]); end
         n_cmp++;
         if (res !== ers[i]) begin n_fail++; $display("FAIL muldiv_result[%0d]: got %h want %h", i, res, ers[i]); end
         n_cmp++;
         if (flg !== efs[i]) begin n_fail++; $display("FAIL muldiv_flags[%0d]: got %b want %b", i, flg, efs[i]); end
         n_cmp++;
         if ({bok, tok} !== 2'b11) begin n_fail++; $display("FAIL muldiv_handshake[%0d]: got busy_ok=%b tail_ok=%b want 1 1", i, bok, tok); end
         last_res = ers[i]; last_flg = efs[i];
      end
   endtask

   task automatic test_pow();
      logic [31:0] as  [7] = '{32'd2, 32'd2, 32'd5, 32'd3, 32'd2, 32'h0001_0000, 32'd3};
      logic [31:0] bs  [7] = '{32'd0, 32'd9, 32'd1, 32'd8, 32'hABCD_0002, 32'd2, 32'd4};
      logic [31:0] ers [7] = '{32'd1, 32'hFFFF_FFFF, 32'd5, 32'd6561, 32'd4, 32'd0, 32'd81};
      logic [3:0]  efs [7] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
      int          els [7] = '{1, 1, 1, 225, 33, 33, 97};
      int lat; logic [31:0] res; logic [3:0] flg; bit bok, tok;
      for (int i = 0; i < 7; i++) begin
         do_op(3'b110, as[i], bs[i], lat, res, flg, bok, tok);
         $display("pow a=%h b=%h result=%h flags=%b cycles=%0d", as[i], bs[i], res, flg, lat);
         n_cmp++;
         if (lat !== els[i]) begin n_fail++; $display("FAIL pow_latency[%0d]: got %0d want %0d", i, lat, els[i]); end
         n_cmp++;
         if (res !== ers[i]) begin n_fail++; $display("FAIL pow_result[%0d]: got %h want %h", i, res, ers[i]); end
         n_cmp++;
         if (flg !== efs[i]) begin n_fail++; $display("FAIL pow_flags[%0d]: got %b want %b", i, flg, efs[i]); end
         n_cmp++;
         if ({bok, tok} !== 2'b11) begin n_fail++; $display("FAIL pow_handshake[%0d]: got busy_ok=%b tail_ok=%b want 1 1", i, bok, tok); end
         last_res = ers[i]; last_flg = efs[i];
      end
   endtask

   task automatic test_abort();
      bit saw_done = 1'b0;
      bit held     = 1'b1;
      start_i = 1'b1; op_i = 3'b101; a_i = 32'd100; b_i = 32'd7;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk_i);
      #1;
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      $display("abort div 100/7 at cycle 10: busy=%b done=%b", busy_o, done_o);
      n_cmp++;
      if ({busy_o, done_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy_o, done_o);
      end
      for (int c = 0; c < 40; c++) begin
         if (done_o === 1'b1) saw_done = 1'b1;
         if (result_o !== last_res || flags_o !== last_flg) held = 1'b0;
         @(posedge clk_i); #1;
      end
      n_cmp++;
      if ({saw_done, held} !== 2'b01) begin
         n_fail++;
         $display("FAIL abort_no_done: got saw_done=%b result_held=%b (result=%h) want 0 1", saw_done, held, result_o);
      end
      start_i = 1'b1; abort_i = 1'b1; op_i = 3'b100; a_i = 32'd1; b_i = 32'd1;
      @(posedge clk_i); #1;
      start_i = 1'b0; abort_i = 1'b0;
      $display("abort+start in idle: busy=%b", busy_o);
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_beats_start: got busy=%b want 0", busy_o);
      end
   endtask

   task automatic test_start_during_run();
      int n_done = 0;
      int first  = -1;
      logic [31:0] res = 32'd0;
      start_i = 1'b1; op_i = 3'b101; a_i = 32'd100; b_i = 32'd7;
      @(posedge clk_i); #1;
      op_i = 3'b100; a_i = 32'd3; b_i = 32'd3;
      for (int c = 1; c <= 60; c++) begin
         if (c > 20) start_i = 1'b0;
         if (done_o === 1'b1) begin
            n_done++;
            if (first < 0) begin first = c; res = result_o; end
         end
         @(posedge clk_i); #1;
      end
      $display("start held in run: dones=%0d first=%0d result=%h", n_done, first, res);
      n_cmp++;
      if (n_done !== 1 || first !== 33) begin
         n_fail++;
         $display("FAIL start_ignored: got dones=%0d at cycle %0d want 1 at cycle 33", n_done, first);
      end
      n_cmp++;
      if (res !== 32'd14) begin n_fail++; $display("FAIL start_ignored_result: got %h want %h", res, 32'd14); end
      last_res = 32'd14; last_flg = 4'b0000;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1 = $urandom, b1 = $urandom, a2 = $urandom;
      logic [31:0] b2 = 32'($urandom_range(1, 1000));
      logic [31:0] r1 = 32'd0, r2 = 32'd0;
      int d1 = -1, d2 = -1;
      bit gap_idle = 1'b0;
      start_i = 1'b1; op_i = 3'b100; a_i = a1; b_i = b1;
      @(posedge clk_i); #1;
      op_i = 3'b101; a_i = a2; b_i = b2;
      for (int c = 1; c <= 120; c++) begin
         if (done_o === 1'b1) begin
            if (d1 < 0) begin d1 = c; r1 = result_o; end
            else if (d2 < 0) begin d2 = c; r2 = result_o; end
         end
         if (d1 > 0 && c == d1 + 1) gap_idle = (busy_o === 1'b0);
         if (d1 > 0 && c == d1 + 2) start_i = 1'b0;
         @(posedge clk_i); #1;
      end
      start_i = 1'b0;
      $display("back-to-back mul %h*%h=%h @%0d, div %h/%h=%h @%0d", a1, b1, r1, d1, a2, b2, r2, d2);
      n_cmp++;
      if (d1 !== 33 || r1 !== a1 * b1) begin
         n_fail++;
         $display("FAIL b2b_first: got %h at cycle %0d want %h at cycle 33", r1, d1, a1 * b1);
      end
      n_cmp++;
      if (gap_idle !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got busy in gap cycle, want idle"); end
      n_cmp++;
      if (d2 !== 67 || r2 !== a2 / b2) begin
         n_fail++;
         $display("FAIL b2b_second: got %h at cycle %0d want %h at cycle 67", r2, d2, a2 / b2);
      end
      last_res = a2 / b2; last_flg = ref_flags(a2 / b2);
   endtask

   task automatic test_reset_midop();
      int lat; logic [31:0] res; logic [3:0] flg; bit bok, tok;
      start_i = 1'b1; op_i = 3'b100; a_i = 32'd1234; b_i = 32'd5678;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      reset_i = 1'b1;
      #1;
      $display("reset mid-mul: busy=%b done=%b result=%h flags=%b", busy_o, done_o, result_o, flags_o);
      n_cmp++;
      if ({busy_o, done_o, result_o, flags_o} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_midop: got busy=%b done=%b result=%h flags=%b want all 0",
                  busy_o, done_o, result_o, flags_o);
      end
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      do_op(3'b100, 32'd123456, 32'd789, lat, res, flg, bok, tok);
      $display("mul after reset: result=%h cycles=%0d", res, lat);
      n_cmp++;
      if (lat !== 33 || res !== 32'd97406784) begin
         n_fail++;
         $display("FAIL reset_then_mul: got %h at cycle %0d want %h at cycle 33", res, lat, 32'd97406784);
      end
      last_res = 32'd97406784; last_flg = 4'b0000;
   endtask

   task automatic test_random();
      int lat, elat, pick; logic [31:0] a, b, res, eres; logic [3:0] flg; logic [2:0] op; bit bok, tok;
      for (int i = 0; i < 40; i++) begin
         pick = int'($urandom_range(0, 9));
         a = $urandom; b = $urandom;
         if (pick < 3) op = 3'b100;
         else if (pick < 6) begin
            op = 3'b101;
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            else if ($urandom_range(0, 1) == 0) b = 32'($urandom_range(1, 255));
         end else if (pick < 9) begin
            op = 3'b110;
            if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 20));
         end else op = 3'($urandom_range(0, 3));
         ref_op(op, a, b, eres, elat);
         do_op(op, a, b, lat, res, flg, bok, tok);
         $display("rand[%0d] op=%b a=%h b=%h result=%h flags=%b cycles=%0d", i, op, a, b, res, flg, lat);
         n_cmp++;
         if (lat !== elat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, elat); end
         n_cmp++;
         if (res !== eres) begin n_fail++; $display("FAIL rand_result[%0d]: got %h want %h", i, res, eres); end
         n_cmp++;
         if (flg !== ref_flags(eres)) begin n_fail++; $display("FAIL rand_flags[%0d]: got %b want %b", i, flg, ref_flags(eres)); end
         n_cmp++;
         if ({bok, tok} !== 2'b11) begin n_fail++; $display("FAIL rand_handshake[%0d]: got busy_ok=%b tail_ok=%b want 1 1", i, bok, tok); end
      end
   endtask

   initial begin
      test_reset();
      test_mul_div();
      test_pow();
      test_abort();
      test_start_during_run();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
